// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the active-low hex segment table, the blank pattern and the
// parameter legality check used by the top level.
// Segment bit order in every 7-bit pattern: bit 0 = a ... bit 6 = g.
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, entry k lights hex digit k (index 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic bit params_ok(input int num_digits, input int refresh_div);
    return (num_digits >= 2) && (num_digits <= 8) &&
           (refresh_div >= 16) && ((refresh_div % 16) == 0);
  endfunction

endpackage

// File: rtl/hex2sevseg.sv
// Hex nibble to active-low seven-segment decoder.
// Ports:
//   nibble - hex value 0..F
//   seg    - active-low segments, bit 0 = a ... bit 6 = g
module hex2sevseg
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment display scanner.
// Each digit owns a slot of REFRESH_DIV clocks; a frame is NUM_DIGITS slots.
// Inputs are sampled into a snapshot once per frame so a frame never tears.
// Optional feature macro: SEVSEG_DIMMING_EN adds the brightness port and
// shortens the anode-on time of each slot to (brightness+1)/16 of the slot.
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous reset, active low
//   digits      - hex nibbles, nibble k = bits [4k+3:4k], digit 0 rightmost
//   dp_in       - decimal point request per digit, 1 = lit
//   lz_blank_en - 1 = blank leading zero digits (digit 0 never blanked)
//   brightness  - duty level 0..15 (SEVSEG_DIMMING_EN only)
//   an          - active-low anode enables, bit k = digit k
//   ca          - active-low cathodes, bit 0 = a ... bit 6 = g
//   dp          - active-low decimal point cathode
//   frame_tick  - high in the first cycle of each frame
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_en,
`ifdef SEVSEG_DIMMING_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              ca,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  if (!params_ok(NUM_DIGITS, REFRESH_DIV)) begin : g_param_check
    $error("sevseg_scan_ctrl: illegal NUM_DIGITS or REFRESH_DIV");
  end

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_d;
  logic                    out_vld;
  logic                    frame_start;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    snap_lz;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              cur_nib;
  logic [6:0]              seg_raw;
  logic                    blank;
  logic                    an_on;

  assign frame_start = (cnt == '0) && (idx == '0);
  // Gated with reset so the pulse is low while the block is held in reset.
  assign frame_tick  = reset && frame_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
    end else if (frame_start) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
      snap_lz     <= lz_blank_en;
    end
  end

  // One-cycle delayed slot position: lines up with the snapshot, which only
  // becomes valid the cycle after the frame start.  out_vld keeps the
  // display dark in that first post-reset cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_d   <= '0;
      out_vld <= 1'b0;
    end else begin
      idx_d   <= idx;
      out_vld <= 1'b1;
    end
  end

  // lead_zero[k] = nibbles NUM_DIGITS-1 down to k are all zero.
  always_comb begin
    logic acc;
    lead_zero = '0;
    acc = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc = acc & (snap_digits[4*k +: 4] == 4'h0);
      lead_zero[k] = acc;
    end
  end

  assign cur_nib = snap_digits[4*idx_d +: 4];
  assign blank   = snap_lz && (idx_d != '0) && lead_zero[idx_d];

  hex2sevseg u_dec (
    .nibble (cur_nib),
    .seg    (seg_raw)
  );

`ifdef SEVSEG_DIMMING_EN
  logic [CW-1:0] cnt_d;
  logic [3:0]    snap_br;
  logic [CW:0]   on_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_d   <= '0;
      snap_br <= '0;
    end else begin
      cnt_d <= cnt;
      if (frame_start) snap_br <= brightness;
    end
  end

  // cnt_d equals the position within the output window being loaded next.
  assign on_len = (CW+1)'({1'b0, snap_br} + 5'd1) * (CW+1)'(REFRESH_DIV / 16);
  assign an_on  = ({1'b0, cnt_d} < on_len);
`else
  assign an_on  = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an <= '1;
      ca <= SEG_BLANK;
      dp <= 1'b1;
    end else if (out_vld) begin
      an <= an_on ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      ca <= blank ? SEG_BLANK : seg_raw;
      dp <= ~snap_dp[idx_d];
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=16.
// Cycle 0 is the cycle in which reset is released; slot s of a frame is
// displayed in cycles 2+16s .. 17+16s counted from that frame's start.
module tb_sevseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank_en = 1'b0;
`ifdef SEVSEG_DIMMING_EN
  logic [3:0]  brightness = 4'd15;
`endif
  logic [3:0]  an;
  logic [6:0]  ca;
  logic        dp;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Active-low hex patterns, bit 0 = a ... bit 6 = g.
  logic [6:0] seg_exp [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .dp_in       (dp_in),
    .lz_blank_en (lz_blank_en),
`ifdef SEVSEG_DIMMING_EN
    .brightness  (brightness),
`endif
    .an          (an),
    .ca          (ca),
    .dp          (dp),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic start_run(input logic [15:0] d, input logic [3:0] dpv, input logic lz);
    reset = 1'b0;
    digits = d;
    dp_in = dpv;
    lz_blank_en = lz;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    digits = 16'h1234;
    dp_in = 4'hF;
    lz_blank_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL rst_an got=%b exp=1111", an); end
    checks++; if (ca !== 7'h7F) begin errors++; $display("FAIL rst_ca got=%h exp=7f", ca); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp got=%b exp=1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
    @(posedge clk);
    #1 reset = 1'b1;
    #1 cyc = 0;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL rel_tick c0 got=%b exp=1", frame_tick); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL rel_an c0 got=%b exp=1111", an); end
    step();
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rel_tick c1 got=%b exp=0", frame_tick); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL rel_an c1 got=%b exp=1111", an); end
    step();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rel_an c2 got=%b exp=1110", an); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL rel_dp c2 got=%b exp=0", dp); end
  endtask

  task automatic test_scan();
    logic [15:0] dv;
    logic [3:0]  exp_an;
    logic        exp_ft;
    int          slot;
    dv = 16'h1234;
    start_run(dv, 4'h0, 1'b0);
    for (int c = 0; c <= 65; c++) begin
      if (c > 0) step();
      exp_ft = (c == 0) || (c == 64);
      checks++; if (frame_tick !== exp_ft) begin errors++; $display("FAIL scan_tick c=%0d got=%b exp=%b", c, frame_tick, exp_ft); end
      if (c >= 2) begin
        slot = (c - 2) / 16;
        exp_an = ~(4'b0001 << slot);
        checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an c=%0d got=%b exp=%b", c, an, exp_an); end
        checks++; if (ca !== seg_exp[dv[4*slot +: 4]]) begin errors++; $display("FAIL scan_ca c=%0d got=%h exp=%h", c, ca, seg_exp[dv[4*slot +: 4]]); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp c=%0d got=%b exp=1", c, dp); end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] exp_ca [4];
    logic [3:0] exp_an;
    int         slot;
    exp_ca = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    start_run(16'h0050, 4'h0, 1'b1);
    for (int c = 1; c <= 65; c++) begin
      step();
      if (c >= 2) begin
        slot = (c - 2) / 16;
        exp_an = ~(4'b0001 << slot);
        checks++; if (an !== exp_an) begin errors++; $display("FAIL lz_an c=%0d got=%b exp=%b", c, an, exp_an); end
        checks++; if (ca !== exp_ca[slot]) begin errors++; $display("FAIL lz_ca c=%0d got=%h exp=%h", c, ca, exp_ca[slot]); end
      end
    end
  endtask

  task automatic test_lz_dp();
    logic [6:0] exp_ca [4];
    logic       exp_dp;
    logic [3:0] exp_an;
    int         slot;
    exp_ca = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    start_run(16'h0000, 4'b0100, 1'b1);
    for (int c = 1; c <= 65; c++) begin
      step();
      if (c >= 2) begin
        slot = (c - 2) / 16;
        exp_an = ~(4'b0001 << slot);
        exp_dp = (slot == 2) ? 1'b0 : 1'b1;
        checks++; if (an !== exp_an) begin errors++; $display("FAIL lzdp_an c=%0d got=%b exp=%b", c, an, exp_an); end
        checks++; if (ca !== exp_ca[slot]) begin errors++; $display("FAIL lzdp_ca c=%0d got=%h exp=%h", c, ca, exp_ca[slot]); end
        checks++; if (dp !== exp_dp) begin errors++; $display("FAIL lzdp_dp c=%0d got=%b exp=%b", c, dp, exp_dp); end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [6:0] exp_ca;
    logic       exp_dp;
    logic [3:0] exp_an;
    int         slot;
    start_run(16'hAAAA, 4'h0, 1'b0);
    for (int c = 1; c <= 129; c++) begin
      step();
      if (c == 20) begin
        digits = 16'hBBBB;
        dp_in = 4'hF;
        lz_blank_en = 1'b1;
      end
      if (c >= 2) begin
        slot = ((c - 2) / 16) % 4;
        exp_an = ~(4'b0001 << slot);
        exp_ca = (c <= 65) ? 7'h08 : 7'h03;
        exp_dp = (c <= 65) ? 1'b1 : 1'b0;
        checks++; if (an !== exp_an) begin errors++; $display("FAIL snap_an c=%0d got=%b exp=%b", c, an, exp_an); end
        checks++; if (ca !== exp_ca) begin errors++; $display("FAIL snap_ca c=%0d got=%h exp=%h", c, ca, exp_ca); end
        checks++; if (dp !== exp_dp) begin errors++; $display("FAIL snap_dp c=%0d got=%b exp=%b", c, dp, exp_dp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    start_run(16'h1234, 4'h0, 1'b0);
    while (cyc < 39) step();
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an got=%b exp=1011", an); end
    checks++; if (ca !== seg_exp[2]) begin errors++; $display("FAIL mid_pre_ca got=%h exp=%h", ca, seg_exp[2]); end
    reset = 1'b0;
    digits = 16'h5678;
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL mid_an got=%b exp=1111", an); end
    checks++; if (ca !== 7'h7F) begin errors++; $display("FAIL mid_ca got=%h exp=7f", ca); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL mid_dp got=%b exp=1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_tick got=%b exp=0", frame_tick); end
    repeat (2) @(posedge clk);
    #2;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL mid_hold_an got=%b exp=1111", an); end
    @(posedge clk);
    #1 reset = 1'b1;
    #1 cyc = 0;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL mid_rel_tick got=%b exp=1", frame_tick); end
    step();
    step();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_rel_an c2 got=%b exp=1110", an); end
    checks++; if (ca !== seg_exp[8]) begin errors++; $display("FAIL mid_rel_ca c2 got=%h exp=%h", ca, seg_exp[8]); end
    while (cyc < 18) step();
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL mid_rel_an c18 got=%b exp=1101", an); end
    checks++; if (ca !== seg_exp[7]) begin errors++; $display("FAIL mid_rel_ca c18 got=%h exp=%h", ca, seg_exp[7]); end
  endtask

`ifdef SEVSEG_DIMMING_EN
  task automatic test_dimming();
    logic [3:0] exp_an;
    int         slot;
    brightness = 4'd3;
    start_run(16'h1234, 4'h0, 1'b0);
    for (int c = 1; c <= 65; c++) begin
      step();
      if (c >= 2) begin
        slot = (c - 2) / 16;
        exp_an = (((c - 2) % 16) < 4) ? ~(4'b0001 << slot) : 4'hF;
        checks++; if (an !== exp_an) begin errors++; $display("FAIL dim3_an c=%0d got=%b exp=%b", c, an, exp_an); end
      end
    end
    brightness = 4'd15;
    start_run(16'h1234, 4'h0, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      step();
      if (c >= 2) begin
        slot = (c - 2) / 16;
        exp_an = ~(4'b0001 << slot);
        checks++; if (an !== exp_an) begin errors++; $display("FAIL dim15_an c=%0d got=%b exp=%b", c, an, exp_an); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_lz_blank();
    test_lz_dp();
    test_snapshot();
    test_reset_mid();
`ifdef SEVSEG_DIMMING_EN
    test_dimming();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
